// File: rtl/chart_recorder_pkg.sv
// Shared types for the chart recorder: note/chart layout, recorder states and
// the note-encoding helper.
package chart_recorder_pkg;

    localparam int unsigned NAME_LEN   = 16;
    localparam int unsigned CHART_LEN  = 360;
    localparam int unsigned NOTE_WIDTH = 7;
    localparam int unsigned IDX_W      = $clog2(CHART_LEN);

    typedef logic [NOTE_WIDTH+1:0] Note;
    typedef Note [CHART_LEN-1:0]   Notes;

    typedef struct packed {
        logic [8*NAME_LEN-1:0] name;
        logic [15:0]           note_cnt;
    } ChartInfo;

    typedef struct packed {
        ChartInfo info;
        Notes     notes;
    } Chart;

    typedef enum logic [2:0] {HOLDOFF, IDLE, RECORD, COMMIT, DONE} RecState;

    localparam Note NU = '0;

    // An empty key vector is a rest, whatever the octave switch says.
    function automatic Note make_note(input logic oct, input logic [NOTE_WIDTH-1:0] keys);
        return (keys == '0) ? NU : {1'b0, oct, keys};
    endfunction

endpackage

// File: rtl/chart_recorder_if.sv
// Key-scan/tempo inputs and chart storage write signals of the recorder.
// master = recorder side, slave = surrounding logic / storage manager side.
interface chart_recorder_if;
    import chart_recorder_pkg::*;

    logic                  start;
    logic                  stop;
    logic                  tick;
    logic [NOTE_WIDTH-1:0] keys;
    logic                  octave_hi;
    logic [7:0]            target_chart_id;
    logic [8*NAME_LEN-1:0] record_name;

    Chart                  new_chart_data;
    logic [7:0]            write_chart_id;
    logic                  recording;
    logic [15:0]           note_cnt;
    logic                  done;
    logic                  reject;

    modport master (
        input  start, stop, tick, keys, octave_hi, target_chart_id, record_name,
        output new_chart_data, write_chart_id, recording, note_cnt, done, reject
    );

    modport slave (
        output start, stop, tick, keys, octave_hi, target_chart_id, record_name,
        input  new_chart_data, write_chart_id, recording, note_cnt, done, reject
    );

endinterface

// File: rtl/chart_note_buffer.sv
// Note storage for one chart: single write port, synchronous clear, all slots
// visible in parallel.
module chart_note_buffer
    import chart_recorder_pkg::*;
(
    input  logic             clk,
    input  logic             sys_rst,
    input  logic             clear,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  Note              data,
    output Notes             notes
);

    always_ff @(posedge clk) begin
        if (sys_rst || clear) begin
            notes <= '0;
        end else if (we && (32'(idx) < CHART_LEN)) begin
            notes[idx] <= data;
        end
    end

endmodule

// File: rtl/chart_recorder.sv
// Records keyboard input into a Chart, one slot per tempo tick, and commits
// it to chart storage via write_chart_id.
module chart_recorder
    import chart_recorder_pkg::*;
#(
    parameter int unsigned MAX_CHART_ID = 2,
    parameter int unsigned INIT_HOLDOFF = 4,
    parameter int unsigned WRITE_CYCLES = 1
) (
    input logic              clk,
    input logic              sys_rst,
    chart_recorder_if.master bus
);

    RecState               state_q;
    RecState               state_d;
    logic [15:0]           hold_cnt;
    logic [15:0]           wr_cnt;
    logic [7:0]            id_q;
    logic [8*NAME_LEN-1:0] name_q;
    logic [15:0]           note_cnt;
    logic                  reject_q;
    Notes                  notes;

    logic id_ok;
    logic accept;
    logic capture;
    logic filled;

    always_comb begin
        id_ok   = (bus.target_chart_id != '0) && (32'(bus.target_chart_id) <= MAX_CHART_ID);
        accept  = (state_q == IDLE) && bus.start && id_ok;
        capture = (state_q == RECORD) && bus.tick && (32'(note_cnt) < CHART_LEN);
        filled  = capture && ((32'(note_cnt) + 1) >= CHART_LEN);
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q <= HOLDOFF;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HOLDOFF: if ((32'(hold_cnt) + 1) >= INIT_HOLDOFF) state_d = IDLE;
            IDLE:    if (accept) state_d = RECORD;
            RECORD:  if (bus.stop || filled) state_d = COMMIT;
            COMMIT:  if ((32'(wr_cnt) + 1) >= WRITE_CYCLES) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = HOLDOFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            hold_cnt <= '0;
            wr_cnt   <= '0;
            id_q     <= '0;
            name_q   <= '0;
            note_cnt <= '0;
            reject_q <= 1'b0;
        end else begin
            reject_q <= (state_q == IDLE) && bus.start && !id_ok;
            hold_cnt <= (state_q == HOLDOFF) ? hold_cnt + 16'd1 : '0;
            wr_cnt   <= (state_q == COMMIT) ? wr_cnt + 16'd1 : '0;
            if (accept) begin
                id_q     <= bus.target_chart_id;
                name_q   <= bus.record_name;
                note_cnt <= '0;
            end else if (capture) begin
                note_cnt <= note_cnt + 16'd1;
            end
        end
    end

    chart_note_buffer u_buf (
        .clk     (clk),
        .sys_rst (sys_rst),
        .clear   (accept),
        .we      (capture),
        .idx     (note_cnt[IDX_W-1:0]),
        .data    (make_note(bus.octave_hi, bus.keys)),
        .notes   (notes)
    );

    // Reset gates the write strobe combinationally so no write leaks out in
    // the cycle reset is asserted.
    always_comb begin
        bus.recording                    = (state_q == RECORD);
        bus.done                         = (state_q == DONE);
        bus.reject                       = reject_q;
        bus.note_cnt                     = note_cnt;
        bus.write_chart_id               = ((state_q == COMMIT) && !sys_rst) ? id_q : '0;
        bus.new_chart_data.info.name     = name_q;
        bus.new_chart_data.info.note_cnt = note_cnt;
        bus.new_chart_data.notes         = notes;
    end

endmodule
